// File: rtl/fetch_decode_queue_pkg.sv
// Core definitions shared by the fetch/decode pipeline blocks.
package fetch_decode_queue_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is queued.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int FDQ_DEPTH_DEFAULT = 4;

  // Count width that can represent 0..depth inclusive.
  function automatic int fdq_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for the decoupling queue.
interface fetch_decode_queue_if
  import fetch_decode_queue_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int ILEN_P = ILEN
);

  logic              in_valid;
  logic              in_ready;
  logic [XLEN_P-1:0] in_pc;
  logic [ILEN_P-1:0] in_instr;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN_P-1:0] out_pc;
  logic [ILEN_P-1:0] out_instr;

  // Queue side: accepts from fetch, presents to decode.
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

  // Environment side: fetch producer plus decode consumer.
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage: DEPTH x WIDTH register array, one write port, one async read port.
module fdq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed slot changes on a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents are don't-care after reset or flush, so the array is not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Decoupling queue between fetch and decode. Circular buffer with separate
// read/write pointers plus an explicit count so full and empty are unambiguous.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH  = FDQ_DEPTH_DEFAULT,
  parameter int XLEN_P = XLEN,
  parameter int ILEN_P = ILEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  fetch_decode_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fdq_cnt_width(DEPTH);
  localparam int ENT_W = XLEN_P + ILEN_P;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             push;
  logic             pop;
  logic             in_ready;
  logic             out_valid;
  logic [ENT_W-1:0] head;

  // Handshake flags come from registered count only, never from the opposite side.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  // Pointer/count next state; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fdq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_storage (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata ({bus.in_pc, bus.in_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // An empty queue shows pc 0 and a NOP rather than stale storage.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? head[ENT_W-1:ILEN_P] : '0;
  assign bus.out_instr = out_valid ? head[ILEN_P-1:0] : ILEN_P'(NOP_INSTR);
  assign occupancy     = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] occupancy;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_decode_queue_if #(.XLEN_P(64), .ILEN_P(32)) bus ();

  fetch_decode_queue #(.DEPTH(4), .XLEN_P(64), .ILEN_P(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins, input logic rdy);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    #2;
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_pc",    bus.out_pc, 64'h0);
    check("rst_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("rst_occ",       64'(occupancy), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_in_ready",  64'(bus.in_ready), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_out_instr", 64'(bus.out_instr), 64'(NOP));
    check("idle_occ",       64'(occupancy), 64'd0);

    // Fill without pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(4 * i), 32'hA0 + 32'(i), 1'b0);
      check("fill_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      check("fill_occ", 64'(occupancy), 64'(i + 1));
      check("fill_head_pc", bus.out_pc, 64'h0);
    end
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_occ",      64'(occupancy), 64'd4);

    // Drain in order
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(bus.out_valid), 64'd1);
      check("drain_pc",    bus.out_pc, 64'(4 * i));
      check("drain_instr", 64'(bus.out_instr), 64'(32'hA0 + 32'(i)));
      tick();
    end
    check("drained_valid", 64'(bus.out_valid), 64'd0);
    check("drained_pc",    bus.out_pc, 64'h0);
    check("drained_instr", 64'(bus.out_instr), 64'(NOP));
    bus.out_ready = 1'b0;

    // Streaming: one push and one pop per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h5000 + 32'(i), 1'b1);
      if (i == 0) begin
        check("stream_first_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        check("stream_valid", 64'(bus.out_valid), 64'd1);
        check("stream_pc",    bus.out_pc, 64'h1000 + 64'(4 * (i - 1)));
        check("stream_occ",   64'(occupancy), 64'd1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("stream_last_pc",    bus.out_pc, 64'h1000 + 64'(4 * 19));
    check("stream_last_instr", 64'(bus.out_instr), 64'(32'h5000 + 32'd19));
    tick();
    check("stream_end_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Full plus pop: no push while full, slot reused next cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h40 + 64'(4 * i), 32'hB0 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 64'h50, 32'hB4, 1'b1);
    check("fullpop_in_ready", 64'(bus.in_ready), 64'd0);
    check("fullpop_head",     bus.out_pc, 64'h40);
    tick();
    check("fullpop_occ3",   64'(occupancy), 64'd3);
    check("fullpop_ready1", 64'(bus.in_ready), 64'd1);
    check("fullpop_head2",  bus.out_pc, 64'h44);
    bus.out_ready = 1'b0;
    tick();
    check("fullpop_occ4", 64'(occupancy), 64'd4);
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("fullpop_drain_pc", bus.out_pc, 64'h44 + 64'(4 * i));
      tick();
    end
    check("fullpop_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h10 + 64'(4 * i), 32'hC0 + 32'(i), 1'b0);
      tick();
    end
    check("preflush_occ", 64'(occupancy), 64'd3);
    drive(1'b1, 64'h100, 32'hC100, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    check("flush_occ",      64'(occupancy), 64'd0);
    check("flush_valid",    64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_instr",    64'(bus.out_instr), 64'(NOP));
    drive(1'b1, 64'h200, 32'hC200, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("postflush_valid", 64'(bus.out_valid), 64'd1);
    check("postflush_pc",    bus.out_pc, 64'h200);
    check("postflush_occ",   64'(occupancy), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("postflush_empty", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h300 + 64'(4 * i), 32'hD0 + 32'(i), 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("prereset_occ", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid",    64'(bus.out_valid), 64'd0);
    check("arst_occ",      64'(occupancy), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_instr",    64'(bus.out_instr), 64'(NOP));
    #2;
    rst = 1'b1;
    tick();
    check("arst_hold_occ", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Decoupling queue between the fetch stage and the decode stage. It captures each fetched {pc, instruction} pair, buffers up to DEPTH entries, and presents them in order to decode over a valid/ready handshake. A branch redirect discards everything buffered. Fetch can run ahead while decode stalls, and decode sees a NOP whenever the queue is empty.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 64, PC width
- ILEN, 32, instruction width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  fetch presents a valid pair this cycle
- in_ready  out  1  queue accepts a pair this cycle
- in_pc  in  XLEN  PC of fetched instruction
- in_instr  in  ILEN  fetched instruction word
- flush  in  1  branch/redirect taken; discard all buffered and incoming entries
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  XLEN  PC of head entry
- out_instr  out  ILEN  instruction of head entry
- occupancy  out  $clog2(DEPTH)+1  current entry count

## Operation
- Circular buffer with write pointer, read pointer (each $clog2(DEPTH) bits, natural wrap DEPTH-1→0), and count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); it depends on registered state only, with no combinational path from out_ready.
- out_valid = (count != 0); out_pc/out_instr = storage[rd_ptr] when out_valid, else pc 0 and instr NOP (32'h00000013).
- Push writes storage[wr_ptr], wr_ptr+1, count+1. Pop advances rd_ptr, count-1. Push and pop together: both pointers advance and count is unchanged.
- Full (count==DEPTH): in_ready=0, so a push cannot occur even if a pop occurs the same cycle; a slot frees on the next cycle.
- Empty: out_valid=0, a pop cannot occur, and a same-cycle push appears at the output next cycle (no bypass).
- flush has highest priority. At the next edge, wr_ptr=rd_ptr=0 and count=0. A push and a pop in the same cycle are both discarded; out_ready is ignored for state. Storage contents are don't-care.
- Entries leave in exactly the order they were accepted; nothing is ever duplicated or dropped except by flush.

## Timing
- Reset (rst=0, asynchronous): pointers and count are 0, so in_ready=1, out_valid=0, out_pc=0, out_instr=NOP, occupancy=0. The queue holds this state until the first rising edge after rst=1.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible at the output after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Flush at edge N: from cycle N+1, out_valid=0, in_ready=1, and occupancy=0. A push in cycle N+1 is accepted normally.
- The outputs are combinational from registered state only. There are no input→output combinational paths.

## Structure
- The shared core package holds XLEN, ILEN, and the NOP encoding constant (32'h00000013). Other stage and pipeline blocks use the same definitions.
- One natural sub-module, fdq_storage: a DEPTH×(XLEN+ILEN) register array with one write port and one asynchronous read port.
- Pointer, count, and handshake control stay in the top module.

## Test plan
- Reset then idle: after rst released, in_ready=1, out_valid=0, out_instr=32'h00000013, occupancy=0.
- Fill without pop: push pc 0x0,0x4,0x8,0xC with instrs 0xA0..0xA3 → in_ready=0 after 4th edge, occupancy=4. Then drain with out_ready=1 → out_pc 0x0,0x4,0x8,0xC in order, then out_valid=0.
- Streaming: in_valid=out_ready=1 continuously for 20 cycles with incrementing pc → occupancy stays at 1 after first cycle, 20 pcs delivered in order. The pointers wrap at least 4 times.
- Full plus pop: queue full, in_valid=1, out_ready=1 → no push that cycle (in_ready=0), occupancy=3 next cycle, push accepted the cycle after.
- Flush with concurrent traffic: 3 entries queued, flush=1 with in_valid=1 pc 0x100 and out_ready=1 → next cycle occupancy=0, out_valid=0, and 0x100 is never output. The next push, pc 0x200, appears as the head.
- Asynchronous reset mid-stream: assert rst=0 between edges with 2 entries queued → out_valid drops to 0 and occupancy to 0 before the next edge.
